// File: rtl/ustream_decoder.sv
// ============================================================================
//  Module   : ustream_decoder
//  Brief    : Windowed unary-to-binary decoder; counts the ones of a
//             stochastic bitstream over 2^BWIDTH cycles and presents the
//             result as unipolar unsigned or bipolar two's complement.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ustream_decoder #(
    parameter int BWIDTH = 8
) (
    input  logic              iClk,
    input  logic              iRstN,
    input  logic              iStart,
    input  logic              iBipolar,
    input  logic              iAbort,
    input  logic              iA,
    output logic              oBusy,
    output logic              oValid,
    input  logic              iReady,
    output logic [BWIDTH-1:0] oData
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [BWIDTH:0] c_WIN_LAST = {1'b0, {BWIDTH{1'b1}}};
    localparam logic [BWIDTH:0] c_ONE      = {{BWIDTH{1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_state_next;
    logic [BWIDTH:0]     r_ones;
    logic [BWIDTH:0]     r_win;
    logic                r_mode;
    logic [BWIDTH-1:0]   r_data;

    logic                w_start;
    logic                w_load;
    logic                w_last;
    logic [BWIDTH:0]     w_ones_next;
    logic [BWIDTH-1:0]   w_sat;
    logic [BWIDTH-1:0]   w_result;

    assign w_last      = (r_win == c_WIN_LAST);
    assign w_ones_next = r_ones + (iA ? c_ONE : '0);

    // Only the all-ones window reaches 2^BWIDTH, so saturation is just the top bit.
    assign w_sat    = w_ones_next[BWIDTH] ? {BWIDTH{1'b1}} : w_ones_next[BWIDTH-1:0];
    assign w_result = r_mode ? {~w_sat[BWIDTH-1], w_sat[BWIDTH-2:0]} : w_sat;

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_load       = 1'b0;
        if (iAbort) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (iStart) begin
                        w_state_next = S_RUN;
                        w_start      = 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_last) begin
                        w_state_next = S_HOLD;
                        w_load       = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (iReady) begin
                        w_state_next = iStart ? S_RUN : S_IDLE;
                        w_start      = iStart;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_ones <= '0;
            r_win  <= '0;
            r_mode <= 1'b0;
            r_data <= '0;
        end else begin
            if (w_start) begin
                r_ones <= '0;
                r_win  <= '0;
                r_mode <= iBipolar;
            end else if (r_state == S_RUN && !iAbort) begin
                r_ones <= w_ones_next;
                r_win  <= r_win + c_ONE;
            end
            if (w_load) begin
                r_data <= w_result;
            end
        end
    end

    assign oBusy  = (r_state == S_RUN);
    assign oValid = (r_state == S_HOLD);
    assign oData  = r_data;

endmodule

`default_nettype wire

// File: tb/tb_ustream_decoder.sv
// ============================================================================
//  Module   : tb_ustream_decoder
//  Brief    : Self-checking bench for ustream_decoder with BWIDTH=4.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ustream_decoder;

    localparam int B = 4;
    localparam int N = 1 << B;

    logic         iClk = 1'b0;
    logic         iRstN = 1'b0;
    logic         iStart = 1'b0;
    logic         iBipolar = 1'b0;
    logic         iAbort = 1'b0;
    logic         iA = 1'b0;
    logic         iReady = 1'b0;
    logic         oBusy;
    logic         oValid;
    logic [B-1:0] oData;

    int errors = 0;
    int checks = 0;

    ustream_decoder #(.BWIDTH(B)) dut (
        .iClk     (iClk),
        .iRstN    (iRstN),
        .iStart   (iStart),
        .iBipolar (iBipolar),
        .iAbort   (iAbort),
        .iA       (iA),
        .oBusy    (oBusy),
        .oValid   (oValid),
        .iReady   (iReady),
        .oData    (oData)
    );

    always #5 iClk = ~iClk;

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    // Reference: count ones, clamp to N-1, offset by N/2 for bipolar.
    function automatic logic [B-1:0] model(input logic [N-1:0] bits, input logic bip);
        int cnt = 0;
        int s;
        for (int i = 0; i < N; i++) cnt += int'(bits[i]);
        s = (cnt > N - 1) ? N - 1 : cnt;
        if (bip) begin
            s = s - N / 2;
            if (s < 0) s = s + N;
        end
        return s[B-1:0];
    endfunction

    task automatic start_conv(input logic bip);
        iStart = 1'b1;
        iBipolar = bip;
        step();
        iStart = 1'b0;
        iBipolar = 1'($urandom);
        checks++;
        if ({oBusy, oValid} !== 2'b10) begin
            errors++;
            $display("FAIL start: busy/valid=%b want 10", {oBusy, oValid});
        end
    endtask

    task automatic run_window(input logic [N-1:0] bits, input logic bip, input string name);
        logic [B-1:0] exp;
        exp = model(bits, bip);
        for (int i = 0; i < N; i++) begin
            iA = bits[i];
            step();
            if (i < N - 1) begin
                if ({oBusy, oValid} !== 2'b10) begin
                    errors++;
                    checks++;
                    $display("FAIL %s latency: sample %0d busy/valid=%b want 10", name, i, {oBusy, oValid});
                end
            end
        end
        iA = 1'b0;
        checks++;
        if ({oBusy, oValid} !== 2'b01) begin
            errors++;
            $display("FAIL %s done: busy/valid=%b want 01", name, {oBusy, oValid});
        end
        checks++;
        if (oData !== exp) begin
            errors++;
            $display("FAIL %s data: got %0d want %0d", name, oData, exp);
        end
    endtask

    task automatic accept();
        iReady = 1'b1;
        step();
        iReady = 1'b0;
        checks++;
        if ({oBusy, oValid} !== 2'b00) begin
            errors++;
            $display("FAIL accept: busy/valid=%b want 00", {oBusy, oValid});
        end
    endtask

    task automatic test_reset();
        iRstN = 1'b0;
        step();
        step();
        checks++;
        if ({oBusy, oValid, oData} !== {2'b00, {B{1'b0}}}) begin
            errors++;
            $display("FAIL reset: busy/valid/data=%b want all 0", {oBusy, oValid, oData});
        end
        iRstN = 1'b1;
        step();
        checks++;
        if ({oBusy, oValid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: busy/valid=%b want 00", {oBusy, oValid});
        end
    endtask

    task automatic test_directed();
        start_conv(1'b0); run_window(16'hFFFF, 1'b0, "uni_ones");  accept();
        start_conv(1'b1); run_window(16'h5555, 1'b1, "bip_alt");   accept();
        start_conv(1'b1); run_window(16'h0000, 1'b1, "bip_zeros"); accept();
        start_conv(1'b1); run_window(16'hFFFF, 1'b1, "bip_ones");  accept();
    endtask

    task automatic test_random();
        logic [N-1:0] bits;
        logic         bip;
        for (int k = 0; k < 8; k++) begin
            bits = N'($urandom);
            if (k == 3) bits = N'($urandom) | N'($urandom);
            bip = 1'($urandom);
            start_conv(bip);
            run_window(bits, bip, "random");
            accept();
        end
    endtask

    task automatic test_backpressure();
        logic [B-1:0] held;
        start_conv(1'b0);
        run_window(16'h0F0F, 1'b0, "bp");
        held = model(16'h0F0F, 1'b0);
        for (int i = 0; i < 5; i++) begin
            iA = 1'($urandom);
            iStart = 1'($urandom);
            step();
            checks++;
            if ({oBusy, oValid} !== 2'b01 || oData !== held) begin
                errors++;
                $display("FAIL backpressure: busy/valid=%b data=%0d want 01 data=%0d", {oBusy, oValid}, oData, held);
            end
        end
        iStart = 1'b0;
        iA = 1'b0;
        accept();
        step();
        checks++;
        if ({oBusy, oValid} !== 2'b00) begin
            errors++;
            $display("FAIL bp_idle: busy/valid=%b want 00", {oBusy, oValid});
        end
    endtask

    task automatic test_back_to_back();
        start_conv(1'b1);
        run_window(16'hFFFF, 1'b1, "b2b_first");
        iReady = 1'b1;
        iStart = 1'b1;
        iBipolar = 1'b0;
        step();
        iReady = 1'b0;
        iStart = 1'b0;
        checks++;
        if ({oBusy, oValid} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_restart: busy/valid=%b want 10", {oBusy, oValid});
        end
        run_window(16'h0124, 1'b0, "b2b_second");
        accept();
    endtask

    task automatic test_abort();
        start_conv(1'b0);
        for (int i = 0; i < 6; i++) begin
            iA = 1'b1;
            step();
        end
        iAbort = 1'b1;
        iStart = 1'b1;
        step();
        iAbort = 1'b0;
        iStart = 1'b0;
        checks++;
        if ({oBusy, oValid} !== 2'b00) begin
            errors++;
            $display("FAIL abort_run: busy/valid=%b want 00", {oBusy, oValid});
        end
        // Abort outranks a simultaneous handshake and restart.
        start_conv(1'b0);
        run_window(16'h00FF, 1'b0, "abort_pre");
        iAbort = 1'b1;
        iReady = 1'b1;
        iStart = 1'b1;
        step();
        iAbort = 1'b0;
        iReady = 1'b0;
        iStart = 1'b0;
        checks++;
        if ({oBusy, oValid} !== 2'b00) begin
            errors++;
            $display("FAIL abort_hold: busy/valid=%b want 00", {oBusy, oValid});
        end
        start_conv(1'b0);
        run_window(16'h0000, 1'b0, "abort_after");
        accept();
    endtask

    task automatic test_async_reset();
        start_conv(1'b0);
        for (int i = 0; i < 4; i++) begin
            iA = 1'b1;
            step();
        end
        #2;
        iRstN = 1'b0;
        #1;
        checks++;
        if ({oBusy, oValid, oData} !== {2'b00, {B{1'b0}}}) begin
            errors++;
            $display("FAIL async_reset: busy/valid/data=%b want all 0", {oBusy, oValid, oData});
        end
        #10;
        iRstN = 1'b1;
        iA = 1'b1;
        for (int i = 0; i < 2 * N; i++) begin
            iReady = 1'($urandom);
            step();
            if ({oBusy, oValid} !== 2'b00) begin
                errors++;
                checks++;
                $display("FAIL post_reset: cycle %0d busy/valid=%b want 00", i, {oBusy, oValid});
            end
        end
        checks++;
        iReady = 1'b0;
        iA = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ustream_decoder.md
Name: ustream_decoder

Overview:
Windowed unary-to-binary decoder. It converts a stochastic bitstream, such as the output of the scaled adder/subtractor blocks, back into a binary value. After a start request it counts the ones in iA over a fixed window of 2^BWIDTH cycles. It then presents the result as a unipolar unsigned value or a bipolar two's-complement value, held under a valid/ready handshake. It sits at the output end of the unary datapath and feeds binary consumers.

Parameters:
BWIDTH, 8, output width in bits; the sampling window is 2^BWIDTH cycles.

Ports:
iClk  input  1  clock; all state updates on the rising edge.
iRstN  input  1  asynchronous, active-low reset.
iStart  input  1  request a new conversion; honoured only in IDLE, or in HOLD together with the completing handshake.
iBipolar  input  1  mode select, sampled on the start edge: 0 = unipolar unsigned, 1 = bipolar two's complement.
iAbort  input  1  synchronous abort; discards the conversion in progress.
iA  input  1  stochastic bitstream under measurement.
oBusy  output  1  high while in RUN.
oValid  output  1  result available (HOLD).
iReady  input  1  consumer accepts the result when high with oValid.
oData  output  BWIDTH  decoded result; stable while oValid is high.

Behaviour:
- Clocking and reset: one clock, iClk. Reset is asynchronous and active-low on iRstN. While reset is low:
  - state goes to IDLE;
  - ones counter, window counter, mode latch and oData are cleared to 0;
  - oBusy = 0 and oValid = 0.
  - Reset mid-RUN or mid-HOLD discards everything. No output is produced after reset release until a new iStart.
- State machine: IDLE, RUN, HOLD.
- IDLE:
  - iStart=1 on an edge -> RUN.
  - On that same edge: ones counter = 0, window counter = 0, mode latch = iBipolar.
- RUN:
  - Every edge: ones counter += iA; window counter += 1.
  - Window counter and ones counter are BWIDTH+1 bits wide, so a full window never wraps.
  - On the edge where window counter == 2^BWIDTH-1 (the 2^BWIDTH-th sample) -> HOLD, and oData is loaded from the final count including that sample.
  - iStart is ignored in RUN.
- Latency: start accepted on edge k; samples taken on edges k+1 .. k+2^BWIDTH; oValid high from just after edge k+2^BWIDTH.
- Arithmetic:
  - Saturate: S = min(count, 2^BWIDTH-1). This applies only to the all-ones window (count = 2^BWIDTH).
  - Unipolar: oData = S.
  - Bipolar: oData = S with its MSB inverted, i.e. S - 2^(BWIDTH-1) in two's complement. Range is -2^(BWIDTH-1) to +2^(BWIDTH-1)-1; the all-ones stream saturates to the positive maximum.
- HOLD:
  - oValid = 1; oData and the mode are stable.
  - iReady=1 -> leave HOLD: go to RUN if iStart=1 on the same edge (back-to-back conversion, counters cleared, new mode latched), otherwise to IDLE.
  - iReady=0 -> remain in HOLD indefinitely; no new samples are counted.
- Abort:
  - iAbort=1 on any edge -> IDLE, with oValid = 0 and oBusy = 0 next cycle.
  - oData keeps its last value but is meaningless without oValid.
  - iAbort has priority over iStart and over the iReady handshake on the same edge.
- Outputs:
  - oBusy = (state == RUN).
  - oValid = (state == HOLD).
  - Both are registered or decoded directly from the state register; there is no combinational path from inputs to outputs.

Test Plan:
- BWIDTH=4, unipolar, iA held 1 for the window -> oValid rises 16 edges after the start edge; oData = 15 (saturated).
- BWIDTH=4, bipolar, iA alternating 1,0 -> count 8; oData = 4'b0000. Repeat with iA=0 constant -> oData = 4'b1000 (-8). Repeat with iA=1 constant -> oData = 4'b0111.
- Backpressure: complete a conversion, hold iReady=0 for 5 cycles while toggling iA and iStart -> oValid stays 1 and oData is unchanged. Then assert iReady -> IDLE next cycle.
- Back-to-back: in HOLD, assert iReady=1 and iStart=1 on the same edge -> direct to RUN with oBusy=1. The second result reflects only the new window (e.g. iA with 3 ones in 16 -> oData = 3).
- Abort: iAbort pulsed at sample 7 of RUN -> IDLE next cycle with no oValid. A following start with iA all 0 -> oData = 0, proving the counters were cleared.
- Reset: drop iRstN asynchronously mid-RUN, between clock edges -> oBusy and oValid go 0 immediately. After release, no oValid appears without iStart.
